// File: rtl/vector_serializer.sv
// Ping-pong vector buffer that accepts a whole N-element vector in one cycle
// and emits it one element per cycle, oldest vector first.
module vector_serializer #(
  parameter  int BITS = 16,
  parameter  int N    = 10,
  localparam int IW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a [N],
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_last,
  output logic [1:0]      pending
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [BITS-1:0] vbuf_q [2][N];
  logic [BITS-1:0] vbuf_d [2][N];
  logic            wr_q, wr_d, rd_q, rd_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            accept, xfer, retire;

  // Handshake flags derive only from registered state and reset, never from in_valid.
  assign in_ready  = !reset && (cnt_q < 2'd2);
  assign out_valid = !reset && (cnt_q != 2'd0);
  assign out_data  = out_valid ? vbuf_q[rd_q][idx_q] : '0;
  assign out_index = reset ? '0 : idx_q;
  assign out_last  = out_valid && (idx_q == LAST);
  assign pending   = cnt_q;

  always_comb begin
    accept = in_valid && in_ready;
    xfer   = out_valid && out_ready;
    retire = xfer && (idx_q == LAST);
    vbuf_d = vbuf_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    idx_d  = idx_q;
    if (accept) begin
      for (int i = 0; i < N; i++) vbuf_d[wr_q][i] = a[i];
      wr_d = ~wr_q;
    end
    if (xfer) begin
      idx_d = retire ? '0 : idx_q + 1'b1;
      if (retire) rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, accept} - {1'b0, retire};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  // Buffer storage is deliberately not reset; the cleared count makes it unreachable.
  always_ff @(posedge clk) vbuf_q <= vbuf_d;

endmodule

// File: tb/tb_vector_serializer.sv
// Directed scenarios plus random traffic, checked every cycle against a
// queue-of-vectors reference model.
module tb_vector_serializer;
  localparam int BITS = 16;
  localparam int N    = 10;
  localparam int IW   = $clog2(N);
  typedef logic [N-1:0][BITS-1:0] vec_t;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [BITS-1:0] a_s [N];
  logic [BITS-1:0] out_data;
  logic [IW-1:0]   out_index;
  logic [1:0]      pending;

  vector_serializer #(.BITS(BITS), .N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .pending(pending));

  always #5 clk = ~clk;

  // Reference model: FIFO of whole vectors plus position within the head vector.
  vec_t q[$];
  int   pos = 0;
  bit   last_acc;
  int   nvec = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic            e_rdy, e_vld;
    logic [BITS-1:0] e_dat;
    e_rdy = !reset && (q.size() < 2);
    e_vld = !reset && (q.size() > 0);
    e_dat = e_vld ? q[0][pos] : '0;
    chk("in_ready",  32'(in_ready),  32'(e_rdy));
    chk("out_valid", 32'(out_valid), 32'(e_vld));
    chk("out_data",  32'(out_data),  32'(e_dat));
    chk("out_index", 32'(out_index), reset ? 32'd0 : 32'(pos));
    chk("out_last",  32'(out_last),  32'(e_vld && pos == N - 1));
    chk("pending",   32'(pending),   32'(q.size()));
  endtask

  // One clock: check at negedge, drive, advance model on the rising edge.
  task automatic cycle(input logic rst_i, input logic iv, input logic ordy, input vec_t v);
    bit acc, xfr;
    check_outputs();
    reset = rst_i; in_valid = iv; out_ready = ordy;
    for (int i = 0; i < N; i++) a_s[i] = v[i];
    acc = !rst_i && iv && (q.size() < 2);
    xfr = !rst_i && ordy && (q.size() > 0);
    @(posedge clk);
    last_acc = acc;
    if (rst_i) begin
      q.delete(); pos = 0;
    end else begin
      if (xfr) begin
        pos++;
        if (pos == N) begin void'(q.pop_front()); pos = 0; end
      end
      if (acc) q.push_back(v);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mkvec(input int base);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = BITS'(base + i);
    return v;
  endfunction

  function automatic vec_t rndvec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = BITS'($urandom);
    return v;
  endfunction

  vec_t z, va, vb, vc, vf;

  initial begin
    z = '0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) a_s[i] = '0;
    @(posedge clk); @(negedge clk);
    cycle(1, 0, 0, z);
    cycle(0, 0, 1, z);

    // Single vector 0001..000A, drain freely.
    cycle(0, 1, 1, mkvec(1));
    for (int i = 0; i < 12; i++) cycle(0, 0, 1, z);

    // A, B, C back-to-back with downstream stalled; C waits for space.
    va = mkvec(16'h0100); vb = mkvec(16'h0200); vc = mkvec(16'h0300);
    cycle(0, 1, 0, va);
    cycle(0, 1, 0, vb);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, vc);
    begin
      int n = 0;
      last_acc = 0;
      while (!last_acc && n < 40) begin cycle(0, 1, 1, vc); n++; end
      chk("c_accepted", 32'(last_acc), 32'd1);
    end
    for (int i = 0; i < 2 * N + 4; i++) cycle(0, 0, 1, z);

    // Alternating out_ready during a vector.
    cycle(0, 1, 1, rndvec());
    for (int i = 0; i < 2 * N + 2; i++) cycle(0, 0, i[0] == 1'b0, z);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, z);

    // New vector accepted on the same edge the current one retires.
    cycle(0, 1, 1, rndvec());
    begin
      int n = 0;
      while (pos != N - 1 && n < 20) begin cycle(0, 0, 1, z); n++; end
    end
    cycle(0, 1, 1, rndvec());
    chk("pend_on_swap", 32'(q.size()), 32'd1);
    for (int i = 0; i < N + 2; i++) cycle(0, 0, 1, z);

    // Reset after 4 elements with a second vector queued.
    vf = rndvec();
    cycle(0, 1, 0, vf);
    cycle(0, 1, 0, rndvec());
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, z);
    cycle(1, 0, 1, z);
    cycle(1, 0, 1, z);
    cycle(0, 0, 1, z);
    cycle(0, 1, 1, mkvec(16'h0A00));
    for (int i = 0; i < N + 2; i++) cycle(0, 0, 1, z);

    // in_valid with all-ones data during reset must not be taken.
    for (int i = 0; i < N; i++) vf[i] = 16'hFFFF;
    cycle(1, 1, 1, vf);
    cycle(1, 1, 1, vf);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, z);

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) != 0, rndvec());
    for (int i = 0; i < 2 * N + 2; i++) cycle(0, 0, 1, z);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/vector_serializer.md
VECTOR_SERIALIZER -- requirements
Module: vector_serializer

Interface
REQ-001 Parameter BITS, default 16, width of one vector element.
REQ-002 Parameter N, default 10, elements per vector; legal range N >= 2.
REQ-003 Localparam IW = $clog2(N), width of the element index.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  reset; synchronous, active-high.
REQ-006 Port in_valid  input  1  a[] holds a valid vector this cycle.
REQ-007 Port in_ready  output  1  block accepts a vector this cycle.
REQ-008 Port a  input  BITS x [N] unpacked array  parallel input vector, e.g. the scaled vector from the scale stage.
REQ-009 Port out_valid  output  1  out_data holds a valid element.
REQ-010 Port out_ready  input  1  downstream accepts the element this cycle.
REQ-011 Port out_data  output  BITS  current element.
REQ-012 Port out_index  output  IW  position of out_data within its vector, 0..N-1.
REQ-013 Port out_last  output  1  current element is index N-1.
REQ-014 Port pending  output  2  number of buffered vectors not yet fully emitted, 0..2.

Function
REQ-015 Two-entry vector buffer (ping-pong): write pointer wr, read pointer rd (1 bit each), count 0..2, element index idx.
REQ-016 in_ready = !reset && (count < 2), combinational from registered state; no pass-through when full, even if the last element drains the same cycle.
REQ-017 Accept = in_valid && in_ready; on accept, all N elements of a[] are stored into buf[wr] and wr toggles.
REQ-018 in_valid while in_ready = 0: vector ignored, no state change.
REQ-019 out_valid = (count > 0); out_data = buf[rd][idx] when out_valid, else 0.
REQ-020 out_index = idx; out_last = out_valid && (idx == N-1).
REQ-021 Transfer = out_valid && out_ready; on transfer with idx < N-1, idx increments.
REQ-022 On transfer with idx == N-1: idx wraps to 0, rd toggles, vector retired.
REQ-023 count next = count + accept - retire; simultaneous accept and retire leave count unchanged.
REQ-024 Latency: vector accepted at edge t -> element 0 presented with out_valid = 1 in cycle after t (1 cycle).
REQ-025 out_ready = 0: out_data, out_index, out_last held stable; idx unchanged.
REQ-026 Throughput: with out_ready = 1 continuously and in_valid every N cycles, one element per cycle, no bubbles.
REQ-027 Elements emitted in order index 0..N-1, vectors in acceptance order.
REQ-028 pending = count.
REQ-029 Stored elements pass through unmodified, bit-exact; no arithmetic on data.

Reset
REQ-030 reset = 1 at an edge: count = 0, idx = 0, wr = 0, rd = 0; buffer contents unchanged, not reset.
REQ-031 While reset = 1: in_ready = 0; out_valid = 0; out_data = 0; out_index = 0; out_last = 0; pending = 0 after first edge.
REQ-032 Reset mid-vector discards all buffered and partially emitted vectors; no element of them appears after reset deasserts.
REQ-033 First cycle after reset deasserts: in_ready = 1, out_valid = 0.

Verification
REQ-034 N=10, single vector a = {16'h0001..16'h000A}, out_ready = 1 -> out_valid on 10 consecutive cycles starting cycle after accept, out_data 0001..000A, out_index 0..9, out_last only at index 9, pending 1 -> 0.
REQ-035 Three back-to-back vectors A, B, C with out_ready = 0 -> A, B accepted, in_ready = 0 for C, pending = 2; release out_ready -> in_ready returns cycle after A's last element, C accepted, order A, B, C.
REQ-036 out_ready toggling 1,0,1,0 during vector -> each element held while out_ready = 0, no element repeated or skipped, 10 transfers total.
REQ-037 pending = 1, accept new vector in same cycle as last element of current vector -> pending stays 1, new vector's element 0 presented next cycle, no bubble.
REQ-038 Reset asserted after 4 elements of vector with second vector queued -> out_valid = 0, in_ready = 0 during reset, pending = 0; after deassert, new vector emitted from index 0 with its own data.
REQ-039 in_valid asserted during reset with data 16'hFFFF -> not accepted, out_valid stays 0 after deassert.
